ula_multiciclo: RTL and testbench
=================================

ULA_MULTICICLO -- requirements
Module: ula_multiciclo

Interface
REQ-001 SHALL have parameter LARGURA, default 8, operand and result width in bits (>= 4).
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port entrada1  input  LARGURA  operand A, unsigned.
REQ-005 SHALL have port entrada2  input  LARGURA  operand B, unsigned.
REQ-006 SHALL have port sinal_ula  input  3  opcode: 000 and, 001 or, 010 add, 011 sub, 100 slt, 101 mul, 110 div, 111 reserved.
REQ-007 SHALL have port inicio  input  1  start request; operands and opcode sampled when accepted.
REQ-008 SHALL have port ocupado  output  1  high while an operation is in progress.
REQ-009 SHALL have port pronto  output  1  one-cycle pulse marking valid results.
REQ-010 SHALL have port saida_ula  output  LARGURA  primary result (mul low half, div quotient).
REQ-011 SHALL have port saida_alta  output  LARGURA  secondary result (mul high half, div remainder, else 0).
REQ-012 SHALL have port zero  output  1  high when saida_ula == 0, valid with results.
REQ-013 SHALL have port div_zero  output  1  high when the last div had entrada2 == 0.

Function
REQ-014 SHALL implement FSM states OCIOSO, CALCULA, FIM.
REQ-015 SHALL accept inicio only in OCIOSO; inicio in CALCULA or FIM SHALL be ignored with no effect.
REQ-016 SHALL register entrada1, entrada2 and sinal_ula on acceptance; later input changes SHALL NOT affect the operation in progress.
REQ-017 Ops and/or/add/sub/slt/111 SHALL go OCIOSO->FIM with results registered; pronto high the cycle after acceptance (latency 1).
REQ-018 add/sub SHALL wrap modulo 2^LARGURA; slt SHALL be an unsigned compare giving 1 or 0; opcode 111 SHALL give 0.
REQ-019 mul SHALL be iterative shift-add, one bit per cycle: CALCULA for exactly LARGURA cycles, then FIM; pronto at cycle LARGURA+1 after acceptance; {saida_alta,saida_ula} = full 2*LARGURA product.
REQ-020 div SHALL be restoring, one bit per cycle, same latency as mul; saida_ula = quotient, saida_alta = remainder.
REQ-021 div with entrada2 == 0 SHALL complete in 1 cycle: saida_ula all ones, saida_alta = entrada1, div_zero = 1; any other op SHALL clear div_zero.
REQ-022 ocupado SHALL be high in CALCULA and FIM only; FIM SHALL last one cycle then return to OCIOSO.
REQ-023 saida_ula, saida_alta, zero, div_zero SHALL hold their values until the next accepted operation completes.
REQ-024 inicio asserted in the cycle FIM returns to OCIOSO SHALL be accepted on the following cycle, not the FIM cycle.

Reset
REQ-025 reset SHALL force OCIOSO and clear ocupado, pronto, saida_ula, saida_alta, zero-source registers and div_zero; zero SHALL read 1 after reset.
REQ-026 reset during CALCULA SHALL abort the operation with no pronto pulse; reset SHALL override inicio in the same cycle.

Configuration
REQ-027 Macro ULA_DIV_EN defined SHALL compile in the iterative divider per REQ-020/021.
REQ-028 Without ULA_DIV_EN, opcode 110 SHALL behave as 111 (latency 1, results 0, div_zero held 0) and no divider logic SHALL be synthesised.

Structure
REQ-029 Package ula_pkg SHALL hold opcode constants (ULA_AND..ULA_RES) and FSM state encodings; the block and the processor control unit SHALL both use it.
REQ-030 Iterative mul/div datapath SHALL be a sub-module ula_iterativa (inputs: operands, op, start; outputs: result pair, done), instantiated once.

Verification (LARGURA = 8)
REQ-031 add 0xF0+0x20 -> pronto 1 cycle after accept, saida_ula 0x10, saida_alta 0x00, zero 0; sub 5-7 -> 0xFE.
REQ-032 mul 200*3 -> pronto 9 cycles after accept, saida_ula 0x58, saida_alta 0x02, ocupado high cycles 1..9.
REQ-033 div 100/7 -> pronto at cycle 9, saida_ula 14, saida_alta 2; div 55/0 -> pronto at cycle 1, 0xFF, 0x37, div_zero 1 (ULA_DIV_EN defined).
REQ-034 mul 15*15 with inicio pulsed again and operands changed at cycle 4 -> second request ignored, result 0x00E1.
REQ-035 reset asserted at cycle 5 of a mul -> no pronto, ocupado 0 next cycle, outputs 0, zero 1; new and 0x0F&0x3C -> 0x0C.
REQ-036 Without ULA_DIV_EN: div 100/7 -> pronto at cycle 1, saida_ula 0, saida_alta 0, div_zero 0.

Source files
------------

// File: rtl/ula_pkg.sv
// ula_pkg: shared definitions for the multi-cycle ALU and the processor
// control unit that drives it.
//   - opcode constants ULA_AND .. ULA_RES (3-bit sinal_ula encoding)
//   - estado_t: ALU sequencer states OCIOSO / CALCULA / FIM
package ula_pkg;

  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b011;
  localparam logic [2:0] ULA_SLT = 3'b100;
  localparam logic [2:0] ULA_MUL = 3'b101;
  localparam logic [2:0] ULA_DIV = 3'b110;
  localparam logic [2:0] ULA_RES = 3'b111;

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    CALCULA = 2'b01,
    FIM     = 2'b10
  } estado_t;

endpackage

// File: rtl/ula_multiciclo_if.sv
// ula_multiciclo_if: request/result bus of the multi-cycle ALU.
//   master (requester): drives entrada1, entrada2, sinal_ula, inicio;
//                       receives ocupado, pronto, saida_ula, saida_alta,
//                       zero, div_zero
//   slave  (ALU)      : the mirror image
interface ula_multiciclo_if #(
  parameter int LARGURA = 8
);
  logic [LARGURA-1:0] entrada1;
  logic [LARGURA-1:0] entrada2;
  logic [2:0]         sinal_ula;
  logic               inicio;
  logic               ocupado;
  logic               pronto;
  logic [LARGURA-1:0] saida_ula;
  logic [LARGURA-1:0] saida_alta;
  logic               zero;
  logic               div_zero;

  modport master (
    output entrada1, entrada2, sinal_ula, inicio,
    input  ocupado, pronto, saida_ula, saida_alta, zero, div_zero
  );

  modport slave (
    input  entrada1, entrada2, sinal_ula, inicio,
    output ocupado, pronto, saida_ula, saida_alta, zero, div_zero
  );
endinterface

// File: rtl/ula_iterativa.sv
// ula_iterativa: one-bit-per-cycle shift-add multiplier and (with
// ULA_DIV_EN defined) restoring divider sharing one 2*LARGURA register.
//   clock, reset           : clock, synchronous active-high reset
//   operando_a, operando_b : operands, captured when inicio is high
//   op                     : opcode (ULA_MUL, or ULA_DIV when enabled)
//   inicio                 : load operands and start LARGURA steps
//   resultado_baixo/alto   : value of the pair after the current step
//                            (mul low/high product, div quotient/remainder)
//   concluido              : high during the cycle whose step is the last
// Optional feature macro: ULA_DIV_EN (divider datapath).
module ula_iterativa
  import ula_pkg::*;
#(
  parameter int LARGURA = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] operando_a,
  input  logic [LARGURA-1:0] operando_b,
  input  logic [2:0]         op,
  input  logic               inicio,
  output logic [LARGURA-1:0] resultado_baixo,
  output logic [LARGURA-1:0] resultado_alto,
  output logic               concluido
);
  localparam int CW = $clog2(LARGURA + 1);

  // p_r holds {high, low}: mul {partial sum, multiplier}, div {remainder, quotient}
  logic [2*LARGURA-1:0] p_r;
  logic [LARGURA-1:0]   m_r;
  logic [CW-1:0]        cont_r;
  logic [LARGURA:0]     soma_s;
  logic [2*LARGURA-1:0] mul_prox_s;
  logic [2*LARGURA-1:0] p_prox_s;
  logic                 carga_s;
`ifdef ULA_DIV_EN
  logic                 div_r;
  logic [LARGURA:0]     desl_s;
  logic [LARGURA+1:0]   dif_s;
  logic [2*LARGURA-1:0] div_prox_s;
`endif

`ifdef ULA_DIV_EN
  assign carga_s = inicio && ((op == ULA_MUL) || (op == ULA_DIV));
`else
  assign carga_s = inicio && (op == ULA_MUL);
`endif

  // One multiply step (and one divide step when enabled) from the current pair
  always_comb begin
    soma_s = {1'b0, p_r[2*LARGURA-1:LARGURA]} + {1'b0, m_r};
    if (p_r[0]) begin
      mul_prox_s = {soma_s, p_r[LARGURA-1:1]};
    end else begin
      mul_prox_s = {1'b0, p_r[2*LARGURA-1:1]};
    end
`ifdef ULA_DIV_EN
    // shift the next dividend bit into the remainder, then trial-subtract
    desl_s = p_r[2*LARGURA-1:LARGURA-1];
    dif_s  = {1'b0, desl_s} - {2'b00, m_r};
    if (dif_s[LARGURA+1]) begin
      div_prox_s = {desl_s[LARGURA-1:0], p_r[LARGURA-2:0], 1'b0};
    end else begin
      div_prox_s = {dif_s[LARGURA-1:0], p_r[LARGURA-2:0], 1'b1};
    end
    if (div_r) begin
      p_prox_s = div_prox_s;
    end else begin
      p_prox_s = mul_prox_s;
    end
`else
    p_prox_s = mul_prox_s;
`endif
  end

  // Operand load on start, then one step per cycle until the counter empties
  always_ff @(posedge clock) begin
    if (reset) begin
      p_r    <= {(2*LARGURA){1'b0}};
      m_r    <= {LARGURA{1'b0}};
      cont_r <= {CW{1'b0}};
`ifdef ULA_DIV_EN
      div_r  <= 1'b0;
`endif
    end else if (carga_s) begin
      p_r    <= {{LARGURA{1'b0}}, operando_a};
      m_r    <= operando_b;
      cont_r <= CW'(LARGURA);
`ifdef ULA_DIV_EN
      div_r  <= (op == ULA_DIV);
`endif
    end else if (cont_r != {CW{1'b0}}) begin
      p_r    <= p_prox_s;
      cont_r <= cont_r - CW'(1);
    end else begin
      p_r    <= p_r;
      cont_r <= cont_r;
    end
  end

  assign concluido       = (cont_r == CW'(1));
  assign resultado_baixo = p_prox_s[LARGURA-1:0];
  assign resultado_alto  = p_prox_s[2*LARGURA-1:LARGURA];
endmodule

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: multi-cycle ALU. Logic/add/sub/slt/reserved finish in one
// cycle; mul (and div when ULA_DIV_EN is defined) iterate LARGURA cycles.
//   clock, reset : clock, synchronous active-high reset
//   bus (slave)  : entrada1/entrada2/sinal_ula/inicio in;
//                  ocupado/pronto/saida_ula/saida_alta/zero/div_zero out
// Optional feature macro: ULA_DIV_EN. Undefined, opcode 110 acts as 111.
module ula_multiciclo
  import ula_pkg::*;
#(
  parameter int LARGURA = 8
) (
  input logic             clock,
  input logic             reset,
  ula_multiciclo_if.slave bus
);
  estado_t            estado_r, estado_prox_s;
  logic               aceita_s, iter_s, carga_iter_s, conclui_iter_s;
  logic               ocupado_s, pronto_s, atualiza_s;
  logic [LARGURA-1:0] it_baixo_s, it_alto_s;
  logic [LARGURA-1:0] simples_baixo_s, simples_alto_s;
  logic               simples_dz_s;
  logic [LARGURA-1:0] novo_baixo_s, novo_alto_s;
  logic               novo_dz_s;
  logic               ocupado_r, pronto_r, zero_r, div_zero_r;
  logic [LARGURA-1:0] saida_ula_r, saida_alta_r;
`ifdef ULA_DIV_EN
  logic               divisor_zero_s;
  assign divisor_zero_s = (bus.entrada2 == {LARGURA{1'b0}});
  // division by zero is answered immediately, not iterated
  assign iter_s = (bus.sinal_ula == ULA_MUL) ||
                  ((bus.sinal_ula == ULA_DIV) && !divisor_zero_s);
`else
  assign iter_s = (bus.sinal_ula == ULA_MUL);
`endif

  ula_iterativa #(.LARGURA(LARGURA)) u_iterativa (
    .clock           (clock),
    .reset           (reset),
    .operando_a      (bus.entrada1),
    .operando_b      (bus.entrada2),
    .op              (bus.sinal_ula),
    .inicio          (carga_iter_s),
    .resultado_baixo (it_baixo_s),
    .resultado_alto  (it_alto_s),
    .concluido       (conclui_iter_s)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_r <= OCIOSO;
    end else begin
      estado_r <= estado_prox_s;
    end
  end

  // Next-state logic
  always_comb begin
    estado_prox_s = estado_r;
    case (estado_r)
      OCIOSO: begin
        if (bus.inicio) begin
          if (iter_s) estado_prox_s = CALCULA;
          else        estado_prox_s = FIM;
        end else begin
          estado_prox_s = OCIOSO;
        end
      end
      CALCULA: begin
        if (conclui_iter_s) estado_prox_s = FIM;
        else                estado_prox_s = CALCULA;
      end
      FIM:     estado_prox_s = OCIOSO;
      default: estado_prox_s = OCIOSO;
    endcase
  end

  // Single-cycle results, computed from the operands at acceptance
  always_comb begin
    simples_alto_s = {LARGURA{1'b0}};
    simples_dz_s   = 1'b0;
    case (bus.sinal_ula)
      ULA_AND: simples_baixo_s = bus.entrada1 & bus.entrada2;
      ULA_OR:  simples_baixo_s = bus.entrada1 | bus.entrada2;
      ULA_ADD: simples_baixo_s = bus.entrada1 + bus.entrada2;
      ULA_SUB: simples_baixo_s = bus.entrada1 - bus.entrada2;
      ULA_SLT: simples_baixo_s = {{(LARGURA-1){1'b0}}, (bus.entrada1 < bus.entrada2)};
`ifdef ULA_DIV_EN
      ULA_DIV: begin
        // only reached here with a zero divisor
        simples_baixo_s = {LARGURA{1'b1}};
        simples_alto_s  = bus.entrada1;
        simples_dz_s    = 1'b1;
      end
`endif
      default: simples_baixo_s = {LARGURA{1'b0}};
    endcase
  end

  // Output decode: handshake flags and result-register load selection
  always_comb begin
    aceita_s     = (estado_r == OCIOSO) && bus.inicio;
    carga_iter_s = aceita_s && iter_s;
    ocupado_s    = (estado_prox_s != OCIOSO);
    pronto_s     = (estado_prox_s == FIM);
    if (aceita_s && !iter_s) begin
      atualiza_s   = 1'b1;
      novo_baixo_s = simples_baixo_s;
      novo_alto_s  = simples_alto_s;
      novo_dz_s    = simples_dz_s;
    end else if ((estado_r == CALCULA) && conclui_iter_s) begin
      atualiza_s   = 1'b1;
      novo_baixo_s = it_baixo_s;
      novo_alto_s  = it_alto_s;
      novo_dz_s    = 1'b0;
    end else begin
      atualiza_s   = 1'b0;
      novo_baixo_s = saida_ula_r;
      novo_alto_s  = saida_alta_r;
      novo_dz_s    = div_zero_r;
    end
  end

  // Registered outputs; results hold until the next operation completes
  always_ff @(posedge clock) begin
    if (reset) begin
      ocupado_r    <= 1'b0;
      pronto_r     <= 1'b0;
      saida_ula_r  <= {LARGURA{1'b0}};
      saida_alta_r <= {LARGURA{1'b0}};
      zero_r       <= 1'b1;
      div_zero_r   <= 1'b0;
    end else begin
      ocupado_r <= ocupado_s;
      pronto_r  <= pronto_s;
      if (atualiza_s) begin
        saida_ula_r  <= novo_baixo_s;
        saida_alta_r <= novo_alto_s;
        zero_r       <= (novo_baixo_s == {LARGURA{1'b0}});
        div_zero_r   <= novo_dz_s;
      end else begin
        saida_ula_r  <= saida_ula_r;
        saida_alta_r <= saida_alta_r;
        zero_r       <= zero_r;
        div_zero_r   <= div_zero_r;
      end
    end
  end

  assign bus.ocupado    = ocupado_r;
  assign bus.pronto     = pronto_r;
  assign bus.saida_ula  = saida_ula_r;
  assign bus.saida_alta = saida_alta_r;
  assign bus.zero       = zero_r;
  assign bus.div_zero   = div_zero_r;
endmodule

// File: tb/tb_ula_multiciclo.sv
// tb_ula_multiciclo: scoreboard bench for ula_multiciclo (LARGURA = 8).
// A model process predicts acceptance and results from plain arithmetic and
// queues them; a monitor process checks the DUT outputs every cycle.
module tb_ula_multiciclo;
  localparam int W = 8;

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       zr;
    logic       dz;
    int         ciclo;
  } esperado_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ula_multiciclo_if #(.LARGURA(W)) bus ();
  ula_multiciclo #(.LARGURA(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  esperado_t fila[$];
  esperado_t cur = '{lo: 8'h00, hi: 8'h00, zr: 1'b1, dz: 1'b0, ciclo: 0};
  int edge_n = 0;
  int livre = 0;
  int jan_ini = -1;
  int jan_fim = -2;
  int reset_edge = -1;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nome, got, exp, edge_n);
    end
  endtask

  // Reference behaviour from the operation definitions; lat = cycles to pronto
  function automatic void referencia(input logic [7:0] a, input logic [7:0] b,
                                     input logic [2:0] op, output esperado_t e,
                                     output int lat);
    int ia, ib, p;
    ia = int'(a);
    ib = int'(b);
    lat = 1;
    e.lo = 8'h00; e.hi = 8'h00; e.dz = 1'b0; e.ciclo = 0;
    case (op)
      3'd0: e.lo = a & b;
      3'd1: e.lo = a | b;
      3'd2: e.lo = 8'((ia + ib) % 256);
      3'd3: e.lo = 8'((ia - ib + 256) % 256);
      3'd4: e.lo = (ia < ib) ? 8'd1 : 8'd0;
      3'd5: begin
        p = ia * ib;
        e.lo = 8'(p % 256);
        e.hi = 8'(p / 256);
        lat = W + 1;
      end
`ifdef ULA_DIV_EN
      3'd6: begin
        if (ib == 0) begin
          e.lo = 8'hFF; e.hi = a; e.dz = 1'b1;
        end else begin
          e.lo = 8'(ia / ib); e.hi = 8'(ia % ib); lat = W + 1;
        end
      end
`endif
      default: ;
    endcase
    e.zr = (e.lo == 8'h00);
  endfunction

  // Model: decides acceptance at each rising edge and queues the expectation
  initial begin : modelo
    esperado_t e;
    int lat;
    forever begin
      @(posedge clock);
      edge_n++;
      if (reset) begin
        fila.delete();
        livre = edge_n + 1;
        jan_ini = -1;
        jan_fim = -2;
        reset_edge = edge_n;
      end else if (bus.inicio && edge_n >= livre) begin
        referencia(bus.entrada1, bus.entrada2, bus.sinal_ula, e, lat);
        e.ciclo = edge_n + lat - 1;
        fila.push_back(e);
        jan_ini = edge_n;
        jan_fim = edge_n + lat - 1;
        livre = edge_n + lat + 1;
      end
    end
  end

  // Monitor: checks handshake every cycle, pops on pronto, compares results
  initial begin : monitor
    esperado_t e;
    forever begin
      @(negedge clock);
      if (edge_n > 0) begin
        if (reset_edge == edge_n) cur = '{lo: 8'h00, hi: 8'h00, zr: 1'b1, dz: 1'b0, ciclo: 0};
        chk("ocupado", {31'd0, bus.ocupado}, {31'd0, (edge_n >= jan_ini && edge_n <= jan_fim)});
        if (bus.pronto === 1'b1) begin
          if (fila.size() == 0) begin
            chk("pronto_sem_pedido", {31'd0, bus.pronto}, 32'd0);
          end else begin
            e = fila.pop_front();
            chk("latencia", edge_n, e.ciclo);
            cur = e;
          end
        end else if (fila.size() > 0 && fila[0].ciclo <= edge_n) begin
          chk("pronto_ausente", {31'd0, bus.pronto}, 32'd1);
          cur = fila.pop_front();
        end
        chk("saida_ula", {24'd0, bus.saida_ula}, {24'd0, cur.lo});
        chk("saida_alta", {24'd0, bus.saida_alta}, {24'd0, cur.hi});
        chk("zero", {31'd0, bus.zero}, {31'd0, cur.zr});
        chk("div_zero", {31'd0, bus.div_zero}, {31'd0, cur.dz});
      end
    end
  end

  task automatic aguardar_livre();
    for (int i = 0; i < 100 && (edge_n + 1 < livre); i++) @(negedge clock);
  endtask

  task automatic emitir(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    @(negedge clock);
    bus.entrada1 = a; bus.entrada2 = b; bus.sinal_ula = op; bus.inicio = 1'b1;
    @(negedge clock);
    bus.inicio = 1'b0;
  endtask

  initial begin : estimulo
    logic [7:0] a, b;
    bus.entrada1 = 8'h00; bus.entrada2 = 8'h00; bus.sinal_ula = 3'd0; bus.inicio = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // directed cases
    aguardar_livre(); emitir(8'hF0, 8'h20, 3'd2);
    aguardar_livre(); emitir(8'd5, 8'd7, 3'd3);
    aguardar_livre(); emitir(8'd200, 8'd3, 3'd5);
    aguardar_livre(); emitir(8'd100, 8'd7, 3'd6);
    aguardar_livre(); emitir(8'd55, 8'd0, 3'd6);
    aguardar_livre(); emitir(8'd9, 8'd9, 3'd4);
    aguardar_livre(); emitir(8'd3, 8'd9, 3'd7);

    // mul with a second request and changed operands mid-operation
    aguardar_livre(); emitir(8'd15, 8'd15, 3'd5);
    repeat (2) @(negedge clock);
    bus.entrada1 = 8'hAA; bus.entrada2 = 8'h55; bus.sinal_ula = 3'd2; bus.inicio = 1'b1;
    @(negedge clock);
    bus.inicio = 1'b0;

    // reset in the middle of a mul, with inicio asserted alongside it
    aguardar_livre(); emitir(8'd200, 8'd3, 3'd5);
    repeat (3) @(negedge clock);
    reset = 1'b1; bus.inicio = 1'b1;
    @(negedge clock);
    reset = 1'b0; bus.inicio = 1'b0;
    aguardar_livre(); emitir(8'h0F, 8'h3C, 3'd0);

    // inicio held high with inputs changing every cycle
    aguardar_livre();
    @(negedge clock);
    bus.inicio = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.entrada1 = 8'($urandom);
      bus.entrada2 = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      bus.sinal_ula = 3'($urandom_range(0, 7));
      @(negedge clock);
    end
    bus.inicio = 1'b0;

    // random traffic with random idle gaps
    for (int i = 0; i < 150; i++) begin
      aguardar_livre();
      repeat ($urandom_range(0, 2)) @(negedge clock);
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      emitir(a, b, 3'($urandom_range(0, 7)));
    end

    repeat (15) @(negedge clock);
    chk("fila_vazia", fila.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
